// File: rtl/cnn_pkg.sv
// Shared types and default image constants for the CNN ingest path.
package cnn_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        UNPACK    = 2'd1,
        WAIT_CORE = 2'd2
    } ld_state_t;

    localparam int IMG_W_D    = 28;
    localparam int IMG_H_D    = 28;
    localparam int PIX_BITS_D = 1;

    function automatic bit pix_bits_legal(input int pb);
        return (pb == 1) || (pb == 2) || (pb == 4) || (pb == 8);
    endfunction

endpackage

// File: rtl/byte_unpacker.sv
// Splits one byte into 8/PIX_BITS pixels, LSB field first, one pixel per cycle.
module byte_unpacker
    import cnn_pkg::*;
#(
    parameter int PIX_BITS = PIX_BITS_D
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [7:0]          byte_in,
    output logic [PIX_BITS-1:0] pix,
    output logic                pix_vld,
    output logic                last_pix
);

    localparam int PPB = 8 / PIX_BITS;
    localparam int PCW = (PPB > 1) ? $clog2(PPB) : 1;

    logic [7:0]     r_sh;
    logic [PCW-1:0] r_pc;
    logic           r_vld;
    logic           w_last;

    assign w_last = r_vld && (r_pc == PCW'(PPB - 1));

    // NOTE: non-blocking assignments keep every register update order-independent.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sh  <= '0;
            r_pc  <= '0;
            r_vld <= 1'b0;
        end else if (load) begin
            r_sh  <= byte_in;
            r_pc  <= '0;
            r_vld <= 1'b1;
        end else if (r_vld) begin
            r_sh  <= r_sh >> PIX_BITS;
            r_pc  <= r_pc + 1'b1;
            if (w_last) begin
                r_vld <= 1'b0;
            end
        end
    end

    assign pix      = r_sh[PIX_BITS-1:0];
    assign pix_vld  = r_vld;
    assign last_pix = w_last;

endmodule

// File: rtl/img_rx_loader.sv
// Byte-stream to pixel-RAM loader with frame start, overrun detection and back-to-back frames.
// Optional idle-gap frame abort is built when RX_TIMEOUT_EN is defined.
module img_rx_loader
    import cnn_pkg::*;
#(
    parameter int IMG_W       = IMG_W_D,
    parameter int IMG_H       = IMG_H_D,
    parameter int PIX_BITS    = PIX_BITS_D,
    parameter int TIMEOUT_CYC = 65536
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [7:0]                         rx_data,
    input  logic                               rx_rdy,
    input  logic                               core_done,
    output logic                               wr_en,
    output logic [$clog2(IMG_W*IMG_H)-1:0]     wr_addr,
    output logic [PIX_BITS-1:0]                wr_data,
    output logic                               start,
    output logic                               busy,
    output logic                               err
);

    localparam int NPIX   = IMG_W * IMG_H;
    localparam int NBYTES = NPIX * PIX_BITS / 8;
    localparam int AW     = $clog2(NPIX);
    localparam int PPB    = 8 / PIX_BITS;

    if (!pix_bits_legal(PIX_BITS) || (NBYTES * 8 != NPIX * PIX_BITS) ||
        (PPB * PIX_BITS != 8) || (TIMEOUT_CYC < 1)) begin : g_bad_cfg
        $error("img_rx_loader: illegal IMG_W/IMG_H/PIX_BITS/TIMEOUT_CYC combination");
    end

    ld_state_t           r_state;
    ld_state_t           w_next;
    logic [7:0]          r_hold;
    logic                r_hv;
    logic [AW-1:0]       r_addr;
    logic                r_err;
    logic                r_start;

    logic                w_load;
    logic [7:0]          w_byte_in;
    logic [PIX_BITS-1:0] w_pix;
    logic                w_pix_vld;
    logic                w_last_pix;
    logic                w_addr_max;
    logic                w_frame_last;
    logic                w_err_set;
    logic                w_abort;

    byte_unpacker #(
        .PIX_BITS (PIX_BITS)
    ) u_unpack (
        .clk      (clk),
        .rst      (rst),
        .load     (w_load),
        .byte_in  (w_byte_in),
        .pix      (w_pix),
        .pix_vld  (w_pix_vld),
        .last_pix (w_last_pix)
    );

    assign w_addr_max   = (r_addr == AW'(NPIX - 1));
    assign w_frame_last = w_last_pix && w_addr_max;

    // Byte routing: a byte landing exactly on the last pixel with hold empty goes straight to sh.
    // NOTE: every signal gets a default first so no path through the block infers a latch.
    always_comb begin
        w_load    = 1'b0;
        w_byte_in = rx_data;
        w_err_set = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_load = rx_rdy;
            end
            UNPACK: begin
                if (w_last_pix && !w_frame_last) begin
                    if (r_hv) begin
                        w_load    = 1'b1;
                        w_byte_in = r_hold;
                    end else begin
                        w_load = rx_rdy;
                    end
                end
                w_err_set = rx_rdy && (r_hv || w_frame_last);
            end
            WAIT_CORE: begin
                w_load    = rx_rdy && core_done;
                w_err_set = rx_rdy && !core_done;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (rx_rdy) w_next = UNPACK;
            end
            UNPACK: begin
                if (w_frame_last) begin
                    w_next = WAIT_CORE;
                end else if (w_last_pix && !w_load) begin
                    w_next = IDLE;
                end
            end
            WAIT_CORE: begin
                if (core_done) w_next = rx_rdy ? UNPACK : IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        wr_en   = (r_state == UNPACK) && w_pix_vld;
        wr_addr = r_addr;
        wr_data = w_pix;
        start   = r_start;
        busy    = (r_state != IDLE);
        err     = r_err;
    end

    // Hold slot is freed on a byte's last pixel: either its content moves to sh or the frame ended.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold <= '0;
            r_hv   <= 1'b0;
        end else if (w_abort) begin
            r_hv <= 1'b0;
        end else if (r_state == UNPACK) begin
            if (w_last_pix) begin
                r_hv <= 1'b0;
            end else if (rx_rdy && !r_hv) begin
                r_hold <= rx_data;
                r_hv   <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr <= '0;
        end else if (w_abort) begin
            r_addr <= '0;
        end else if (w_pix_vld) begin
            r_addr <= w_addr_max ? '0 : r_addr + 1'b1;
        end
    end

    // A new error in the frame-completion cycle takes priority over the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err   <= 1'b0;
            r_start <= 1'b0;
        end else begin
            r_start <= w_frame_last;
            if (w_err_set || w_abort) begin
                r_err <= 1'b1;
            end else if (w_frame_last) begin
                r_err <= 1'b0;
            end
        end
    end

`ifdef RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] r_gap;
    logic          w_gap_run;

    assign w_gap_run = (r_state == IDLE) && (r_addr != '0) && !rx_rdy;
    assign w_abort   = w_gap_run && (r_gap == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gap <= '0;
        end else if (w_gap_run && !w_abort) begin
            r_gap <= r_gap + 1'b1;
        end else begin
            r_gap <= '0;
        end
    end
`else
    assign w_abort = 1'b0;
`endif

endmodule

// File: doc/img_rx_loader.md
# img_rx_loader

Parametrised image-ingest block between the UART receiver and the CNN core. It accepts a byte stream on the `rx_data`/`rx_rdy` handshake and unpacks each byte LSB-first into pixels of `PIX_BITS` bits. Pixels are written sequentially into the core's input RAM, and `start` is pulsed when a full frame has landed. This generalises the fixed 28×28×1-bit (98-byte) loader to arbitrary image size and pixel depth. It adds overrun/drop detection and back-to-back frame handling.

## Interface
Parameters:
- `IMG_W`, default 28: image width in pixels.
- `IMG_H`, default 28: image height in pixels.
- `PIX_BITS`, default 1: bits per pixel. Legal values are 1, 2, 4, 8. `IMG_W*IMG_H*PIX_BITS` must be divisible by 8; elaboration fails otherwise.
- `TIMEOUT_CYC`, default 65536: idle-gap limit. Used only under `RX_TIMEOUT_EN`.
- Derived localparams: `NPIX = IMG_W*IMG_H`, `NBYTES = NPIX*PIX_BITS/8`, `AW = $clog2(NPIX)`, `PPB = 8/PIX_BITS`.

Ports:
- `clk`, in, 1: single clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `rx_data`, in, 8: received byte.
- `rx_rdy`, in, 1: one-cycle strobe qualifying `rx_data`.
- `core_done`, in, 1: core finished the current frame (pulse).
- `wr_en`, out, 1: input-RAM write strobe.
- `wr_addr`, out, AW: pixel address, 0..NPIX-1.
- `wr_data`, out, PIX_BITS: pixel value.
- `start`, out, 1: one-cycle pulse when a frame is complete.
- `busy`, out, 1: high in UNPACK or WAIT_CORE.
- `err`, out, 1: sticky error flag. Cleared on the next `start`.

## Operation
- **Byte buffering:** two byte slots.
  - Active shift register `sh`.
  - One-entry holding register `hold` with valid bit `hv`.
- **State IDLE:**
  - On `rx_rdy`, load `sh`, set pixel counter `pc=0`, go to UNPACK.
- **State UNPACK:**
  - Each cycle: `wr_en=1`, `wr_data=sh[PIX_BITS-1:0]`, `wr_addr=addr`.
  - Then shift `sh` right by PIX_BITS, increment `addr` and `pc`.
  - After PPB pixels:
    - If `hv`, move `hold` to `sh`, clear `hv`, stay in UNPACK.
    - Else return to IDLE.
- **Arrivals during UNPACK:**
  - `rx_rdy` with `hv=0` stores the byte into `hold`.
  - `rx_rdy` with `hv=1` drops the byte and sets `err` (overrun).
- **Frame complete:**
  - When the write to `addr=NPIX-1` happens, pulse `start` on the next cycle and enter WAIT_CORE.
  - `addr` wraps to 0.
  - `hold` is cleared.
- **State WAIT_CORE:**
  - `rx_rdy` bytes are discarded and set `err`.
  - `core_done` returns the block to IDLE.
  - If `rx_rdy` and `core_done` occur in the same cycle, the byte is accepted: load `sh`, go to UNPACK.
- **Reset:**
  - All outputs are 0.
  - `addr=0`, `hv=0`, state IDLE.
  - Reset mid-frame discards the partial frame; no `start` is issued.
- **Pixel order:** byte k, bit field j (from the LSB) maps to pixel `k*PPB+j`.

## Timing
- Write latency: the first `wr_en` occurs one cycle after the `rx_rdy` edge is sampled.
- A byte occupies PPB consecutive write cycles. A held byte starts on the cycle immediately after, with no bubble.
- `start` asserts exactly one cycle after the final `wr_en`, for exactly one cycle.
- `busy` rises the cycle after the first accepted `rx_rdy` of a frame. It falls the cycle after `core_done`.
- `err` rises the cycle after the offending `rx_rdy`. It clears in the same cycle `start` asserts, unless a new error occurs that cycle; the new error wins.
- Sustained throughput: one byte per PPB cycles with no loss. Two bytes within PPB cycles are also absorbed, via `hold`.

## Configuration
- `RX_TIMEOUT_EN` defined:
  - A gap counter runs while a frame is partially loaded (`addr≠0` or UNPACK), in IDLE.
  - If TIMEOUT_CYC cycles pass with no `rx_rdy`, the frame is aborted: `addr=0`, `hv=0`, `err=1`, state IDLE, no `start`.
  - The counter resets on every `rx_rdy`.
- `RX_TIMEOUT_EN` undefined:
  - No counter is built.
  - A partial frame waits indefinitely for further bytes.

## Structure
- Shared package `cnn_pkg` holds:
  - The `ld_state_t` enum (IDLE, UNPACK, WAIT_CORE).
  - Default image constants `IMG_W_D=28`, `IMG_H_D=28`, `PIX_BITS_D=1`.
- One sub-module, `byte_unpacker`: `sh` plus the pixel counter. It takes `load`/`byte_in` and outputs `pix`, `pix_vld`, `last_pix`, parametrised by PIX_BITS.
- The top level holds the FSM, `hold`, `addr`, `err`, and the timeout.

## Test plan
- **Default config, 98 bytes of 0xA5, 50-cycle spacing:**
  - Pixels repeat 1,0,1,0,0,1,0,1.
  - The last write is at `wr_addr=783`.
  - `start` pulses once, one cycle later, and `err` stays 0.
- **PIX_BITS=4, IMG 4×4, 8 bytes 0x21,0x43,…:**
  - `wr_data` sequence is 1,2,3,4,… at addr 0..15.
  - `start` follows addr 15.
- **Default config, two bytes on consecutive cycles, then a third inside the 8-cycle window:**
  - The first two bytes are written back-to-back over 16 cycles.
  - The third byte is dropped and `err=1`.
- **WAIT_CORE behaviour:**
  - A byte arriving in WAIT_CORE is dropped with `err=1`.
  - After `core_done`, a new frame loads from addr 0.
  - `err` clears at the next `start`.
- **Reset mid-frame:**
  - Assert `rst` after 40 bytes.
  - All outputs go to 0 immediately.
  - The next 98 bytes produce a full frame starting at addr 0.
- **`RX_TIMEOUT_EN`, TIMEOUT_CYC=100, 10 bytes then silence:**
  - After 100 idle cycles `err=1` and there is no `start`.
  - The next byte writes addr 0.
